// File: rtl/prod_acc_s8_pkg.sv
// Shared types and constants for the signed product accumulator.
// Optional build macro used by the slice: PROD_ACC_SATURATE_EN (clamp instead of wrap).
package prod_acc_pkg;

    localparam int unsigned PROD_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Largest positive value of an acc_w-bit signed number, in the low acc_w bits.
    function automatic logic [31:0] sat_max(input int unsigned acc_w);
        logic [32:0] v;
        v = (33'd1 << (acc_w - 1)) - 33'd1;
        return v[31:0];
    endfunction

    // Most negative value of an acc_w-bit signed number, in the low acc_w bits.
    function automatic logic [31:0] sat_min(input int unsigned acc_w);
        return ~sat_max(acc_w);
    endfunction

endpackage

// File: rtl/prod_acc_s8_if.sv
// Handshake bundle between the multiplier stage, the accumulator and its consumer.
interface prod_acc_s8_if #(
    parameter int unsigned ACC_W = 12,
    parameter int unsigned CNT_W = 4
);
    import prod_acc_pkg::*;

    logic              start;
    logic [CNT_W-1:0]  num_terms;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              overflow;
    logic              busy;

    modport master (
        output start, num_terms, in_valid, prod, out_ready,
        input  in_ready, out_valid, acc_out, overflow, busy
    );

    modport slave (
        input  start, num_terms, in_valid, prod, out_ready,
        output in_ready, out_valid, acc_out, overflow, busy
    );

endinterface

// File: rtl/prod_acc_s8_acc_add_sat.sv
// Combinational ACC_W signed adder for one 8-bit product, with overflow detect.
// PROD_ACC_SATURATE_EN defined: result clamps on overflow; otherwise it wraps.
module acc_add_sat
    import prod_acc_pkg::*;
#(
    parameter int unsigned ACC_W = 12
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W:0] sum_x;

    // one guard bit: overflow when guard and sign disagree; guard is the true sign
    always_comb begin
        sum_x = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
        ovf   = sum_x[ACC_W] ^ sum_x[ACC_W-1];
        sum   = sum_x[ACC_W-1:0];
`ifdef PROD_ACC_SATURATE_EN
        if (ovf) begin
            sum = sum_x[ACC_W] ? sat_min(ACC_W)[ACC_W-1:0] : sat_max(ACC_W)[ACC_W-1:0];
        end
`endif
    end

endmodule

// File: rtl/prod_acc_s8.sv
// Accumulates a job of num_terms signed 8-bit products and presents the sum.
// Build option: PROD_ACC_SATURATE_EN selects clamping arithmetic (default wraps).
module prod_acc_s8
    import prod_acc_pkg::*;
#(
    parameter int unsigned ACC_W = 12,
    parameter int unsigned CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    prod_acc_s8_if.slave bus
);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, sum;
    logic             ovf_q, add_ovf;
    logic [CNT_W-1:0] cnt_q, nterms_q;
    logic             load, accept;

    acc_add_sat #(.ACC_W(ACC_W)) u_add (
        .acc  (acc_q),
        .prod (bus.prod),
        .sum  (sum),
        .ovf  (add_ovf)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state logic and handshake decode; outputs follow the registered state only
    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = (bus.num_terms == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (cnt_q == nterms_q - CNT_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // job registers: cleared on start, updated on each accepted product
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            nterms_q <= '0;
            ovf_q    <= 1'b0;
        end else if (load) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            nterms_q <= bus.num_terms;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            acc_q    <= sum;
            cnt_q    <= cnt_q + CNT_W'(1);
            ovf_q    <= ovf_q | add_ovf;
        end
    end

    assign bus.acc_out  = acc_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_prod_acc_s8.sv
// Scoreboard bench for prod_acc_s8: a 12-bit accumulator instance and an 8-bit one.
module tb_prod_acc_s8;

    logic clk;
    logic rst_n;

    prod_acc_s8_if #(.ACC_W(12), .CNT_W(4)) a_if ();
    prod_acc_s8_if #(.ACC_W(8),  .CNT_W(4)) b_if ();

    prod_acc_s8 #(.ACC_W(12), .CNT_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    prod_acc_s8 #(.ACC_W(8),  .CNT_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

    int n_cmp = 0;
    int n_bad = 0;
    int stim[$];
    int exp_acc[$];
    bit exp_ovf[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference sum of stim[0..n-1] at width w, wrapping or clamping per build
    function automatic void model(input int w, input int n, output int acc, output bit ovf);
        int mx, mn, s;
        mx  = (1 << (w - 1)) - 1;
        mn  = -(1 << (w - 1));
        acc = 0;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = acc + stim[i];
            if (s > mx || s < mn) begin
                ovf = 1'b1;
`ifdef PROD_ACC_SATURATE_EN
                s = (s > mx) ? mx : mn;
`else
                s = (s > mx) ? s - (1 << w) : s + (1 << w);
`endif
            end
            acc = s;
        end
    endfunction

    // full job on the 12-bit instance: gap idle cycles between products,
    // hold cycles of out_ready low, optional start pokes while busy
    task automatic run_job(input int n, input int gap, input int hold, input bit poke, input string name);
        int e_acc, accepted, guard, got;
        bit e_ovf;
        logic [11:0] held;
        model(12, n, e_acc, e_ovf);
        exp_acc.push_back(e_acc);
        exp_ovf.push_back(e_ovf);
        a_if.start     = 1'b1;
        a_if.num_terms = 4'(n);
        step();
        a_if.start = 1'b0;
        n_cmp++;
        if (a_if.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy_after_start: got %b required 1", name, a_if.busy);
        end
        n_cmp++;
        if (a_if.in_ready !== (n > 0)) begin
            n_bad++;
            $display("FAIL %s in_ready_after_start: got %b required %b", name, a_if.in_ready, (n > 0));
        end
        accepted = 0;
        guard    = 0;
        while (accepted < n && guard < 200) begin
            if (gap > 0 && accepted > 0) begin
                a_if.in_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    a_if.prod = 8'($urandom);
                    step();
                end
            end
            a_if.in_valid = 1'b1;
            a_if.prod     = 8'(stim[accepted]);
            if (poke) begin
                a_if.start     = 1'b1;
                a_if.num_terms = 4'd15;
            end
            if (a_if.in_ready === 1'b1) accepted++;
            step();
            guard++;
            a_if.start = 1'b0;
        end
        if (accepted < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s accept_timeout: got %0d accepts required %0d", name, accepted, n);
        end
        // keep offering a product: nothing more may be taken
        a_if.in_valid = 1'b1;
        a_if.prod     = 8'sd127;
        n_cmp++;
        if (a_if.out_valid !== 1'b1 || a_if.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done_latency: got out_valid=%b in_ready=%b required 1/0", name, a_if.out_valid, a_if.in_ready);
        end
        held          = a_if.acc_out;
        a_if.out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            step();
            n_cmp++;
            if (a_if.out_valid !== 1'b1 || a_if.acc_out !== held) begin
                n_bad++;
                $display("FAIL %s hold: got out_valid=%b acc=%h required 1/%h", name, a_if.out_valid, a_if.acc_out, held);
            end
        end
        if (exp_acc.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s scoreboard_empty: got 0 entries required 1", name);
        end else begin
            e_acc = exp_acc.pop_front();
            e_ovf = exp_ovf.pop_front();
            got   = int'($signed(a_if.acc_out));
            n_cmp++;
            if (got !== e_acc) begin
                n_bad++;
                $display("FAIL %s acc_out: got %0d required %0d", name, got, e_acc);
            end
            n_cmp++;
            if (a_if.overflow !== e_ovf) begin
                n_bad++;
                $display("FAIL %s overflow: got %b required %b", name, a_if.overflow, e_ovf);
            end
        end
        a_if.out_ready = 1'b1;
        if (poke) begin
            a_if.start     = 1'b1;
            a_if.num_terms = 4'd3;
        end
        step();
        a_if.out_ready = 1'b0;
        a_if.start     = 1'b0;
        a_if.in_valid  = 1'b0;
        n_cmp++;
        if (a_if.out_valid !== 1'b0 || a_if.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s return_idle: got out_valid=%b busy=%b required 0/0", name, a_if.out_valid, a_if.busy);
        end
        step();
        n_cmp++;
        if (a_if.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s stay_idle: got busy=%b required 0", name, a_if.busy);
        end
    endtask

    // back-to-back job on the 8-bit instance
    task automatic job_b(input int n, input string name);
        int e_acc, got;
        bit e_ovf;
        model(8, n, e_acc, e_ovf);
        exp_acc.push_back(e_acc);
        exp_ovf.push_back(e_ovf);
        b_if.start     = 1'b1;
        b_if.num_terms = 4'(n);
        step();
        b_if.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (b_if.in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL %s in_ready[%0d]: got %b required 1", name, i, b_if.in_ready);
            end
            b_if.in_valid = 1'b1;
            b_if.prod     = 8'(stim[i]);
            step();
        end
        b_if.in_valid = 1'b0;
        n_cmp++;
        if (b_if.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s out_valid: got %b required 1", name, b_if.out_valid);
        end
        e_acc = exp_acc.pop_front();
        e_ovf = exp_ovf.pop_front();
        got   = int'($signed(b_if.acc_out));
        n_cmp++;
        if (got !== e_acc) begin
            n_bad++;
            $display("FAIL %s acc_out: got %0d required %0d", name, got, e_acc);
        end
        n_cmp++;
        if (b_if.overflow !== e_ovf) begin
            n_bad++;
            $display("FAIL %s overflow: got %b required %b", name, b_if.overflow, e_ovf);
        end
        b_if.out_ready = 1'b1;
        step();
        b_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        n_cmp++;
        if ({a_if.busy, a_if.in_ready, a_if.out_valid, a_if.overflow} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b required 0000", {a_if.busy, a_if.in_ready, a_if.out_valid, a_if.overflow});
        end
        n_cmp++;
        if (a_if.acc_out !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_acc: got %h required 000", a_if.acc_out);
        end
        step();
    endtask

    task automatic test_basic();
        stim = '{64, -56, 10};
        run_job(3, 0, 0, 1'b0, "basic");
    endtask

    task automatic test_gaps_stall();
        stim = '{100, -128, 127, -3};
        run_job(4, 2, 5, 1'b0, "gaps_stall");
    endtask

    task automatic test_back_to_back();
        stim = '{};
        for (int i = 0; i < 15; i++) stim.push_back(-128);
        run_job(15, 0, 0, 1'b0, "full_neg");
        stim = '{};
        for (int i = 0; i < 15; i++) stim.push_back(127);
        run_job(15, 0, 1, 1'b0, "full_pos");
    endtask

    task automatic test_overflow_w8();
        stim = '{64, 64};
        job_b(2, "w8_edge");
        stim = '{100, 100, -50};
        job_b(3, "w8_continue");
        stim = '{-5};
        job_b(1, "w8_sticky_clear");
    endtask

    task automatic test_zero_terms();
        stim = '{};
        run_job(0, 0, 2, 1'b0, "zero_terms");
    endtask

    task automatic test_reset_mid_job();
        a_if.start     = 1'b1;
        a_if.num_terms = 4'd4;
        step();
        a_if.start    = 1'b0;
        a_if.in_valid = 1'b1;
        a_if.prod     = 8'sd10;
        step();
        a_if.prod = 8'sd20;
        step();
        a_if.in_valid = 1'b0;
        rst_n         = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++;
        if ({a_if.busy, a_if.in_ready, a_if.out_valid, a_if.overflow} !== 4'b0000 || a_if.acc_out !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_mid_job: got flags=%b acc=%h required 0000/000",
                     {a_if.busy, a_if.in_ready, a_if.out_valid, a_if.overflow}, a_if.acc_out);
        end
        step();
        n_cmp++;
        if (a_if.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_partial: got out_valid=%b required 0", a_if.out_valid);
        end
        stim = '{-8};
        run_job(1, 0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_start_ignored();
        stim = '{-100, 50};
        run_job(2, 0, 0, 1'b1, "start_ignored");
    endtask

    initial begin
        rst_n          = 1'b0;
        a_if.start     = 1'b0;
        a_if.num_terms = '0;
        a_if.in_valid  = 1'b0;
        a_if.prod      = '0;
        a_if.out_ready = 1'b0;
        b_if.start     = 1'b0;
        b_if.num_terms = '0;
        b_if.in_valid  = 1'b0;
        b_if.prod      = '0;
        b_if.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_gaps_stall();
        test_back_to_back();
        test_overflow_w8();
        test_zero_terms();
        test_reset_mid_job();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
